// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state constants and index-width helper for the UART serializer
package uart_pkg;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/custom_fifo_uart_tx.sv
// custom_fifo_uart_tx: latches one DEPTH-element word and issues it element 0 first as bytes to the UART
module custom_fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        arstn,
  input  logic                        valid_i,
  input  logic [DEPTH-1:0][WIDTH-1:0] write_data,
  output logic                        ready_o,
  output logic                        tx_valid,
  output logic [WIDTH-1:0]            tx_data,
  input  logic                        tx_ready,
  output logic                        done_o
);
  localparam int IW = idx_w(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  logic [0:0]                  state;
  logic [IW-1:0]               idx;
  logic [DEPTH-1:0][WIDTH-1:0] buffer;
  logic                        done;

  assign ready_o  = state == IDLE;
  assign tx_valid = state == SEND;
  assign tx_data  = buffer[idx];
  assign done_o   = done;

  // word capture, byte stepping and the one-cycle done pulse after the final byte
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state  <= IDLE;
      idx    <= '0;
      buffer <= '0;
      done   <= 1'b0;
    end else begin
      done <= tx_valid && tx_ready && idx == LAST;
      if (ready_o && valid_i) begin
        buffer <= write_data;
        idx    <= '0;
        state  <= SEND;
      end else if (tx_valid && tx_ready) begin
        if (idx == LAST) begin
          state <= IDLE;
          idx   <= '0;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_custom_fifo_uart_tx.sv
// tb_custom_fifo_uart_tx: directed and randomized checks of the word-to-byte serializer at DEPTH 4, 3 and 1
module tb_custom_fifo_uart_tx;
  logic clk, arstn;
  logic v4, rdy4, txv4, txr4, done4;
  logic [3:0][7:0] wd4;
  logic [7:0] txd4;
  logic v3, rdy3, txv3, txr3, done3;
  logic [2:0][7:0] wd3;
  logic [7:0] txd3;
  logic v1, rdy1, txv1, txr1, done1;
  logic [0:0][7:0] wd1;
  logic [7:0] txd1;
  logic [7:0] q4[$], q3[$], q1[$];
  int nd4;
  int checks = 0;
  int failures = 0;

  custom_fifo_uart_tx #(.WIDTH(8), .DEPTH(4)) d4 (
    .clk(clk), .arstn(arstn), .valid_i(v4), .write_data(wd4), .ready_o(rdy4),
    .tx_valid(txv4), .tx_data(txd4), .tx_ready(txr4), .done_o(done4));
  custom_fifo_uart_tx #(.WIDTH(8), .DEPTH(3)) d3 (
    .clk(clk), .arstn(arstn), .valid_i(v3), .write_data(wd3), .ready_o(rdy3),
    .tx_valid(txv3), .tx_data(txd3), .tx_ready(txr3), .done_o(done3));
  custom_fifo_uart_tx #(.WIDTH(8), .DEPTH(1)) d1 (
    .clk(clk), .arstn(arstn), .valid_i(v1), .write_data(wd1), .ready_o(rdy1),
    .tx_valid(txv1), .tx_data(txd1), .tx_ready(txr1), .done_o(done1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // receive-side collector: records every byte the UART accepts, plus done pulses of the DEPTH-4 unit
  always @(posedge clk) begin
    if (txv4 && txr4) q4.push_back(txd4);
    if (txv3 && txr3) q3.push_back(txd3);
    if (txv1 && txr1) q1.push_back(txd1);
    if (done4) nd4 <= nd4 + 1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    return 8'((w >> (8 * i)) & 32'hFF);
  endfunction

  task automatic run_word(input logic [31:0] w, input int stall_at, input int stall_n, input bit poke);
    q4.delete();
    v4 = 1'b1;
    wd4 = w;
    chk("acc_rdy", 32'(rdy4), 1);
    step();
    v4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < ((i == stall_at) ? stall_n : 0); k++) begin
        chk("stall_txv", 32'(txv4), 1);
        chk("stall_txd", 32'(txd4), 32'(byte_of(w, i)));
        txr4 = 1'b0;
        if (poke) begin
          v4 = 1'b1;
          wd4 = 32'hDEADBEEF;
        end
        step();
      end
      txr4 = 1'b1;
      v4 = 1'b0;
      chk("txv", 32'(txv4), 1);
      chk("txd", 32'(txd4), 32'(byte_of(w, i)));
      chk("busy_rdy", 32'(rdy4), 0);
      chk("no_done", 32'(done4), 0);
      step();
    end
    chk("done", 32'(done4), 1);
    chk("done_rdy", 32'(rdy4), 1);
    chk("idle_txv", 32'(txv4), 0);
    step();
    chk("done_pulse", 32'(done4), 0);
    chk("no_extra", 32'(txv4), 0);
    chk("bytes", 32'(q4.size()), 4);
    for (int i = 0; i < 4 && i < q4.size(); i++) chk("order", 32'(q4[i]), 32'(byte_of(w, i)));
  endtask

  task automatic lb3(input logic [23:0] w);
    logic [23:0] rx;
    int t;
    q3.delete();
    chk("lb3_rdy", 32'(rdy3), 1);
    v3 = 1'b1;
    wd3 = w;
    step();
    v3 = 1'b0;
    t = 0;
    while (!done3 && t < 100) begin
      txr3 = 1'($urandom_range(0, 1));
      step();
      t++;
    end
    chk("lb3_timeout", 32'(done3), 1);
    rx = '0;
    for (int i = 0; i < 3 && i < q3.size(); i++) rx[i*8 +: 8] = q3[i];
    chk("lb3_count", 32'(q3.size()), 3);
    chk("lb3_word", 32'(rx), 32'(w));
  endtask

  task automatic lb1(input logic [7:0] w);
    int t;
    q1.delete();
    chk("lb1_rdy", 32'(rdy1), 1);
    v1 = 1'b1;
    wd1 = w;
    step();
    v1 = 1'b0;
    t = 0;
    while (!done1 && t < 100) begin
      txr1 = 1'($urandom_range(0, 1));
      step();
      t++;
    end
    chk("lb1_timeout", 32'(done1), 1);
    chk("lb1_count", 32'(q1.size()), 1);
    chk("lb1_word", (q1.size() > 0) ? 32'(q1[0]) : 32'hFFFF_FFFF, 32'(w));
  endtask

  initial begin
    logic [31:0] a, b, w;
    int n;
    arstn = 1'b0;
    nd4 = 0;
    v4 = 1'b0; wd4 = '0; txr4 = 1'b1;
    v3 = 1'b0; wd3 = '0; txr3 = 1'b1;
    v1 = 1'b0; wd1 = '0; txr1 = 1'b1;
    repeat (2) step();
    chk("rst_rdy", 32'(rdy4), 1);
    chk("rst_txv", 32'(txv4), 0);
    chk("rst_txd", 32'(txd4), 0);
    chk("rst_done", 32'(done4), 0);
    arstn = 1'b1;
    step();
    chk("post_rst_rdy", 32'(rdy4), 1);
    run_word(32'h44332211, -1, 0, 1'b0);
    run_word(32'h44332211, 1, 3, 1'b0);
    run_word($urandom, 1, 2, 1'b1);
    run_word($urandom, $urandom_range(0, 3), $urandom_range(1, 4), 1'b0);
    q4.delete();
    a = $urandom;
    b = $urandom;
    v4 = 1'b1;
    wd4 = a;
    step();
    wd4 = b;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_a_txv", 32'(txv4), 1);
      chk("b2b_a_txd", 32'(txd4), 32'(byte_of(a, i)));
      step();
    end
    chk("b2b_done", 32'(done4), 1);
    chk("b2b_rdy", 32'(rdy4), 1);
    chk("b2b_gap", 32'(txv4), 0);
    step();
    v4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_b_txv", 32'(txv4), 1);
      chk("b2b_b_txd", 32'(txd4), 32'(byte_of(b, i)));
      step();
    end
    chk("b2b_done2", 32'(done4), 1);
    step();
    chk("b2b_bytes", 32'(q4.size()), 8);
    for (int i = 0; i < 8 && i < q4.size(); i++)
      chk("b2b_order", 32'(q4[i]), 32'(byte_of((i < 4) ? a : b, i % 4)));
    w = $urandom;
    v4 = 1'b1;
    wd4 = w;
    step();
    v4 = 1'b0;
    step();
    step();
    chk("mid_txd", 32'(txd4), 32'(byte_of(w, 2)));
    n = nd4;
    #1 arstn = 1'b0;
    #1 chk("rst_async_txv", 32'(txv4), 0);
    step();
    step();
    arstn = 1'b1;
    chk("abort_rdy", 32'(rdy4), 1);
    chk("abort_txv", 32'(txv4), 0);
    step();
    step();
    chk("abort_done", 32'(done4), 0);
    chk("abort_no_done", 32'(nd4), 32'(n));
    run_word($urandom, -1, 0, 1'b0);
    for (int i = 0; i < 8; i++) lb3(24'($urandom));
    for (int i = 0; i < 8; i++) lb1(8'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/custom_fifo_uart_tx.md
Name: custom_fifo_uart_tx

Overview:
Word-to-byte serializer on the transmit path of the UART link. It accepts one parallel word of DEPTH elements, each WIDTH bits wide, through a valid/ready handshake. It then issues the elements one at a time, element 0 first, to the UART byte transmitter using a per-byte valid/ready handshake. It mirrors the receive-side collector, which places the first received byte in element 0, so a word round-trips unchanged.

Parameters:
- WIDTH, 8, bits per element (one UART frame payload).
- DEPTH, 4, elements per word; legal range 1 and up.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- arstn  input  1  asynchronous reset, active-low.
- valid_i  input  1  a word is presented on write_data.
- write_data  input  [DEPTH-1:0][WIDTH-1:0]  word to send; element 0 is sent first.
- ready_o  output  1  block can accept a word this cycle.
- tx_valid  output  1  tx_data holds a byte for the UART transmitter.
- tx_data  output  WIDTH  current byte.
- tx_ready  input  1  UART transmitter accepts tx_data this cycle.
- done_o  output  1  one-cycle pulse after the last byte of a word is accepted.

Behaviour:
- Reset (arstn low, asynchronous):
  - state = IDLE, element index = 0, word buffer = 0.
  - tx_valid = 0, tx_data = 0, done_o = 0, ready_o = 1 once reset is released.
- Word accept:
  - ready_o = (state == IDLE), purely from state.
  - A word is accepted when valid_i && ready_o at a rising edge: write_data is latched, index is set to 0, state goes to SEND.
  - valid_i while not ready is ignored. No buffering of a second word.
- SEND state:
  - tx_valid = 1; tx_data = buffer[index]. Both are combinational from registers.
  - First byte appears on the cycle after acceptance (latency 1).
  - While tx_valid && !tx_ready, tx_data and index hold stable.
  - On tx_valid && tx_ready with index < DEPTH-1: index increments and the next byte is presented the next cycle, with no bubble.
  - On tx_valid && tx_ready with index == DEPTH-1: state goes to IDLE, index goes to 0, done_o = 1 for exactly the next cycle.
- IDLE state: tx_valid = 0. tx_data keeps showing buffer[0] and has no meaning while tx_valid is low.
- Back-to-back words:
  - ready_o rises in the same cycle done_o is high.
  - A new word can be accepted in that cycle.
  - Minimum gap between the last byte of one word and the first byte of the next is one idle cycle.
- Index width: max(1, $clog2(DEPTH)).
  - Wrap comparison uses an explicit DEPTH-1 constant, so non-power-of-2 DEPTH works.
  - For DEPTH = 1, every word sends exactly one byte.
- tx_ready while tx_valid is 0 has no effect.
- Reset asserted mid-word:
  - The partially sent word is discarded; tx_valid drops asynchronously.
  - After release, the block is in IDLE and no done_o is produced for the aborted word.

Decomposition:
- Shared uart_pkg holds the state enum (IDLE, SEND) and a helper constant function for index width, max(1, $clog2(n)).
- Single module; the FSM, index counter and buffer are small enough that no sub-module is warranted.

Test Plan:
- Basic word, WIDTH=8, DEPTH=4, tx_ready tied to 1: word {0x44,0x33,0x22,0x11} (element 0 = 0x11) -> tx_data sequence 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles starting 1 cycle after acceptance; done_o pulses once; ready_o is low for exactly 4 cycles.
- Backpressure: tx_ready low for 3 cycles at byte 1 -> tx_data stays 0x22 and tx_valid stays 1 during the stall; sequence and count are unchanged; done_o appears 3 cycles later than in the unstalled case.
- Busy drop: pulse valid_i with word 0xDEADBEEF while in SEND -> not accepted; the original word completes intact and no extra bytes follow.
- Back-to-back: hold valid_i high with two different words -> second word is accepted in the done_o cycle; 8 bytes total in correct order with one idle cycle between the words.
- Reset mid-word: assert arstn low after byte 2 -> tx_valid = 0 immediately; after release ready_o = 1, no done_o appears, and a fresh word sends from element 0.
- Loopback with the receive-side collector, DEPTH=1 and DEPTH=3: random words through a UART model -> the collector's parallel output equals the input word in every case.
